// File: rtl/lsu_completion_tracker.sv
`default_nettype none
// ============================================================================
// Module      : lsu_completion_tracker
// Description : LSU-side producer of the scoreboard clear interface. Queues
//               LD/ST issues in order, forwards them to DRAM over a
//               valid/ready request channel and retires them on in-order
//               DRAM responses with a one-cycle done pulse carrying the
//               warp and encoded thread mask to release.
// Ports       : clk, rst_n (async, active-low)
//               i_issue_*    - scheduler issue channel (o_issue_ready back)
//               o_mem_req_*  - DRAM request channel (i_mem_req_ready back)
//               i_mem_resp_valid - in-order completion pulse
//               o_done_bit, o_warp_num_clear, o_threads_mask_clear - clear
//               o_occupancy  - entries held (queued + in flight)
//               o_resp_error - sticky: response with nothing in flight
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_completion_tracker #(
    parameter int DEPTH      = 4,
    parameter int WARP_BITS  = 2,
    parameter int MASK_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_issue_valid,
    output logic                       o_issue_ready,
    input  logic [WARP_BITS-1:0]       i_issue_warp,
    input  logic [MASK_WIDTH-1:0]      i_issue_mask,
    input  logic                       i_issue_store,
    output logic                       o_mem_req_valid,
    input  logic                       i_mem_req_ready,
    output logic [WARP_BITS-1:0]       o_mem_req_warp,
    output logic [MASK_WIDTH-1:0]      o_mem_req_mask,
    output logic                       o_mem_req_store,
    input  logic                       i_mem_resp_valid,
    output logic                       o_done_bit,
    output logic [WARP_BITS-1:0]       o_warp_num_clear,
    output logic [MASK_WIDTH-1:0]      o_threads_mask_clear,
    output logic [$clog2(DEPTH):0]     o_occupancy,
    output logic                       o_resp_error
);

    localparam int                c_AW    = $clog2(DEPTH);
    localparam int                c_PW    = c_AW + 1;
    localparam logic [c_PW-1:0]   c_DEPTH = c_PW'(DEPTH);

    // Storage is deliberately not reset; pointers alone define validity.
    logic [WARP_BITS-1:0]  r_mem_warp  [DEPTH];
    logic [MASK_WIDTH-1:0] r_mem_mask  [DEPTH];
    logic                  r_mem_store [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_req_ptr;
    logic [c_PW-1:0] r_rd_ptr;

    logic                  r_done_bit;
    logic [WARP_BITS-1:0]  r_warp_clear;
    logic [MASK_WIDTH-1:0] r_mask_clear;
    logic                  r_resp_error;

    logic [c_PW-1:0] w_occ;
    logic [c_PW-1:0] w_in_flight;
    logic            w_issue;
    logic            w_req_fire;
    logic            w_retire;
    logic            w_unexpected;

    assign w_occ        = r_wr_ptr - r_rd_ptr;
    assign w_in_flight  = r_req_ptr - r_rd_ptr;

    // Ready depends on registered occupancy only: a retire in the same
    // cycle does not free a slot until the following cycle.
    assign o_issue_ready   = (w_occ < c_DEPTH);
    assign o_mem_req_valid = (r_req_ptr != r_wr_ptr);

    assign w_issue      = i_issue_valid && o_issue_ready;
    assign w_req_fire   = o_mem_req_valid && i_mem_req_ready;
    // A request accepted this very cycle is not yet in flight, so a response
    // arriving alongside it is treated as unexpected.
    assign w_retire     = i_mem_resp_valid && (w_in_flight != '0);
    assign w_unexpected = i_mem_resp_valid && (w_in_flight == '0);

    assign o_mem_req_warp  = r_mem_warp[r_req_ptr[c_AW-1:0]];
    assign o_mem_req_mask  = r_mem_mask[r_req_ptr[c_AW-1:0]];
    assign o_mem_req_store = r_mem_store[r_req_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_mem_warp[r_wr_ptr[c_AW-1:0]]  <= i_issue_warp;
            r_mem_mask[r_wr_ptr[c_AW-1:0]]  <= i_issue_mask;
            r_mem_store[r_wr_ptr[c_AW-1:0]] <= i_issue_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_req_ptr    <= '0;
            r_rd_ptr     <= '0;
            r_done_bit   <= 1'b0;
            r_warp_clear <= '0;
            r_mask_clear <= '0;
            r_resp_error <= 1'b0;
        end else begin
            if (w_issue) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_req_fire) begin
                r_req_ptr <= r_req_ptr + 1'b1;
            end
            r_done_bit <= w_retire;
            if (w_retire) begin
                r_warp_clear <= r_mem_warp[r_rd_ptr[c_AW-1:0]];
                r_mask_clear <= r_mem_mask[r_rd_ptr[c_AW-1:0]];
                r_rd_ptr     <= r_rd_ptr + 1'b1;
            end
            if (w_unexpected) begin
                r_resp_error <= 1'b1;
            end
        end
    end

    assign o_done_bit           = r_done_bit;
    assign o_warp_num_clear     = r_warp_clear;
    assign o_threads_mask_clear = r_mask_clear;
    assign o_occupancy          = w_occ;
    assign o_resp_error         = r_resp_error;

endmodule
`default_nettype wire

// File: tb/tb_lsu_completion_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_completion_tracker
// Description : Directed and random-traffic bench for lsu_completion_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_completion_tracker;

    typedef struct packed {
        logic [1:0] w;
        logic [3:0] m;
        logic       s;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic       issue_ready;
    logic [1:0] issue_warp;
    logic [3:0] issue_mask;
    logic       issue_store;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_warp;
    logic [3:0] req_mask;
    logic       req_store;
    logic       resp_valid;
    logic       done_bit;
    logic [1:0] warp_clr;
    logic [3:0] mask_clr;
    logic [2:0] occ;
    logic       resp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_completion_tracker #(.DEPTH(4), .WARP_BITS(2), .MASK_WIDTH(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_issue_valid        (issue_valid),
        .o_issue_ready        (issue_ready),
        .i_issue_warp         (issue_warp),
        .i_issue_mask         (issue_mask),
        .i_issue_store        (issue_store),
        .o_mem_req_valid      (req_valid),
        .i_mem_req_ready      (req_ready),
        .o_mem_req_warp       (req_warp),
        .o_mem_req_mask       (req_mask),
        .o_mem_req_store      (req_store),
        .i_mem_resp_valid     (resp_valid),
        .o_done_bit           (done_bit),
        .o_warp_num_clear     (warp_clr),
        .o_threads_mask_clear (mask_clr),
        .o_occupancy          (occ),
        .o_resp_error         (resp_err)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_warp  = '0;
        issue_mask  = '0;
        issue_store = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        total++;
        if (done_bit !== 1'b0 || occ !== 3'd0 || issue_ready !== 1'b1 ||
            req_valid !== 1'b0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: done=%b occ=%0d rdy=%b rv=%b err=%b, need 0 0 1 0 0",
                     done_bit, occ, issue_ready, req_valid, resp_err);
        end
    endtask

    task automatic test_single();
        req_ready   = 1'b1;
        issue_valid = 1'b1;
        issue_warp  = 2'd2;
        issue_mask  = 4'h5;
        issue_store = 1'b0;
        step();
        issue_valid = 1'b0;
        total++;
        if (req_valid !== 1'b1 || req_warp !== 2'd2 || req_mask !== 4'h5 || req_store !== 1'b0) begin
            bad++;
            $display("FAIL single_req: v=%b w=%0d m=%h s=%b, need 1 2 5 0",
                     req_valid, req_warp, req_mask, req_store);
        end
        step();
        total++;
        if (req_valid !== 1'b0 || occ !== 3'd1) begin
            bad++;
            $display("FAIL single_sent: v=%b occ=%0d, need 0 1", req_valid, occ);
        end
        step();
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        total++;
        if (done_bit !== 1'b1 || warp_clr !== 2'd2 || mask_clr !== 4'h5 || occ !== 3'd0) begin
            bad++;
            $display("FAIL single_done: done=%b w=%0d m=%h occ=%0d, need 1 2 5 0",
                     done_bit, warp_clr, mask_clr, occ);
        end
        step();
        total++;
        if (done_bit !== 1'b0 || warp_clr !== 2'd2 || mask_clr !== 4'h5) begin
            bad++;
            $display("FAIL single_hold: done=%b w=%0d m=%h, need 0 2 5", done_bit, warp_clr, mask_clr);
        end
        req_ready = 1'b0;
    endtask

    task automatic test_full_stall();
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_warp  = 2'(i);
            issue_mask  = 4'(i + 1);
            issue_store = i[0];
            step();
            total++;
            if (occ !== 3'(i + 1) || req_warp !== 2'd0) begin
                bad++;
                $display("FAIL fill_%0d: occ=%0d reqw=%0d, need %0d 0", i, occ, req_warp, i + 1);
            end
        end
        total++;
        if (issue_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: got %b need 0", issue_ready);
        end
        issue_warp = 2'd1;
        issue_mask = 4'hF;
        step();
        step();
        total++;
        if (occ !== 3'd4 || req_warp !== 2'd0 || req_mask !== 4'h1 || req_valid !== 1'b1) begin
            bad++;
            $display("FAIL full_stall: occ=%0d w=%0d m=%h v=%b, need 4 0 1 1",
                     occ, req_warp, req_mask, req_valid);
        end
        issue_valid = 1'b0;
        req_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (req_valid !== 1'b1 || req_warp !== 2'(i) || req_mask !== 4'(i + 1) ||
                req_store !== i[0]) begin
                bad++;
                $display("FAIL drain_req_%0d: v=%b w=%0d m=%h s=%b, need 1 %0d %0d %b",
                         i, req_valid, req_warp, req_mask, req_store, i, i + 1, i[0]);
            end
            step();
        end
        total++;
        if (req_valid !== 1'b0 || occ !== 3'd4) begin
            bad++;
            $display("FAIL drain_end: v=%b occ=%0d, need 0 4", req_valid, occ);
        end
    endtask

    // Continues from four in-flight entries (warps 0..3, masks 1..4).
    task automatic test_full_retire();
        logic [1:0] ew [4];
        logic [3:0] em [4];
        resp_valid  = 1'b1;
        issue_valid = 1'b1;
        issue_warp  = 2'd3;
        issue_mask  = 4'hA;
        issue_store = 1'b1;
        total++;
        if (issue_ready !== 1'b0) begin
            bad++;
            $display("FAIL fr_ready_pre: got %b need 0", issue_ready);
        end
        step();
        resp_valid = 1'b0;
        total++;
        if (done_bit !== 1'b1 || warp_clr !== 2'd0 || mask_clr !== 4'h1 || occ !== 3'd3) begin
            bad++;
            $display("FAIL fr_retire: done=%b w=%0d m=%h occ=%0d, need 1 0 1 3",
                     done_bit, warp_clr, mask_clr, occ);
        end
        step();
        issue_valid = 1'b0;
        total++;
        if (occ !== 3'd4 || done_bit !== 1'b0) begin
            bad++;
            $display("FAIL fr_accept: occ=%0d done=%b, need 4 0", occ, done_bit);
        end
        step();
        ew[0] = 2'd1; ew[1] = 2'd2; ew[2] = 2'd3; ew[3] = 2'd3;
        em[0] = 4'h2; em[1] = 4'h3; em[2] = 4'h4; em[3] = 4'hA;
        resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (done_bit !== 1'b1 || warp_clr !== ew[i] || mask_clr !== em[i] || occ !== 3'(3 - i)) begin
                bad++;
                $display("FAIL b2b_%0d: done=%b w=%0d m=%h occ=%0d, need 1 %0d %h %0d",
                         i, done_bit, warp_clr, mask_clr, occ, ew[i], em[i], 3 - i);
            end
        end
        resp_valid = 1'b0;
        req_ready  = 1'b0;
        step();
        total++;
        if (done_bit !== 1'b0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: done=%b err=%b, need 0 0", done_bit, resp_err);
        end
    endtask

    task automatic test_unexpected();
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        total++;
        if (done_bit !== 1'b0 || occ !== 3'd0 || resp_err !== 1'b1) begin
            bad++;
            $display("FAIL unexp: done=%b occ=%0d err=%b, need 0 0 1", done_bit, occ, resp_err);
        end
        // A response alongside the accept of its own request is still unexpected.
        req_ready   = 1'b1;
        issue_valid = 1'b1;
        issue_warp  = 2'd1;
        issue_mask  = 4'h7;
        step();
        issue_valid = 1'b0;
        resp_valid  = 1'b1;
        step();
        resp_valid = 1'b0;
        step();
        step();
        total++;
        if (resp_err !== 1'b1 || occ !== 3'd1 || done_bit !== 1'b0) begin
            bad++;
            $display("FAIL unexp_sticky: err=%b occ=%0d done=%b, need 1 1 0", resp_err, occ, done_bit);
        end
        req_ready = 1'b0;
    endtask

    task automatic test_midrun_reset();
        do_reset();
        req_ready   = 1'b1;
        issue_valid = 1'b1;
        issue_warp  = 2'd3;
        issue_mask  = 4'h9;
        step();
        issue_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        total++;
        if (done_bit !== 1'b0 || occ !== 3'd0 || issue_ready !== 1'b1 ||
            req_valid !== 1'b0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: done=%b occ=%0d rdy=%b rv=%b err=%b, need 0 0 1 0 0",
                     done_bit, occ, issue_ready, req_valid, resp_err);
        end
        rst_n      = 1'b1;
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        total++;
        if (resp_err !== 1'b1 || done_bit !== 1'b0) begin
            bad++;
            $display("FAIL dropped_resp: err=%b done=%b, need 1 0", resp_err, done_bit);
        end
        req_ready = 1'b0;
        do_reset();
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int   sent = 0;
        int   errs = 0;
        logic exp_rdy, exp_val, do_ret, do_fire, do_acc;
        for (int c = 0; c < 10000; c++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_warp  = 2'($urandom);
            issue_mask  = 4'($urandom);
            issue_store = 1'($urandom);
            req_ready   = ($urandom_range(0, 2) != 0);
            resp_valid  = (sent > 0) && ($urandom_range(0, 2) == 0);
            exp_rdy = (q.size() < 4);
            exp_val = (sent < q.size());
            if (issue_ready !== exp_rdy || req_valid !== exp_val ||
                (exp_val && {req_warp, req_mask, req_store} !== q[sent])) begin
                errs++;
                if (errs < 5)
                    $display("FAIL rand_req c=%0d: rdy=%b v=%b f=%h, need %b %b",
                             c, issue_ready, req_valid, {req_warp, req_mask, req_store}, exp_rdy, exp_val);
            end
            do_ret  = resp_valid && (sent > 0);
            do_fire = exp_val && req_ready;
            do_acc  = issue_valid && exp_rdy;
            e = '{w: issue_warp, m: issue_mask, s: issue_store};
            step();
            if (do_ret) begin
                ent_t h;
                h = q.pop_front();
                sent--;
                if (done_bit !== 1'b1 || warp_clr !== h.w || mask_clr !== h.m) begin
                    errs++;
                    if (errs < 5)
                        $display("FAIL rand_done c=%0d: done=%b w=%0d m=%h, need 1 %0d %h",
                                 c, done_bit, warp_clr, mask_clr, h.w, h.m);
                end
            end else if (done_bit !== 1'b0) begin
                errs++;
                if (errs < 5) $display("FAIL rand_nodone c=%0d: done=%b need 0", c, done_bit);
            end
            if (do_fire) sent++;
            if (do_acc) q.push_back(e);
            if (occ !== 3'(q.size()) || occ > 3'd4) begin
                errs++;
                if (errs < 5) $display("FAIL rand_occ c=%0d: occ=%0d need %0d", c, occ, q.size());
            end
        end
        idle_inputs();
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL random_traffic: %0d errors, need 0", errs);
        end
        total++;
        if (resp_err !== 1'b0) begin
            bad++;
            $display("FAIL random_resp_err: got %b need 0", resp_err);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_single();
        test_full_stall();
        test_full_retire();
        test_unexpected();
        test_midrun_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
